// File: rtl/fsm_seq_gen.sv
// fsm_seq_gen: serial pattern generator.
// Latches a WIDTH-bit pattern on start and shifts it out MSB first, repeating
// the frame rpt+1 times with GAP_CYCLES idle cycles between frames. A consumer
// stall (hold) freezes the shift sequence. done pulses once when the last frame
// finishes and the FSM re-enters IDLE.
// Optional feature: define FSM_SEQ_GEN_PARITY_EN to append one even-parity bit
// (PAR state) after every frame. Default build has no parity state or logic.
module fsm_seq_gen #(
  parameter int   WIDTH      = 21,
  parameter int   GAP_CYCLES = 2,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [3:0]       rpt,
  input  logic             hold,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef FSM_SEQ_GEN_PARITY_EN
    PAR   = 2'd3,
`endif
    GAP   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;      // index of the bit being sent
  logic [WIDTH-1:0] sh, sh_n;        // working shift copy, MSB is next bit
  logic [WIDTH-1:0] pat, pat_n;      // latched pattern, reloaded per repeat
  logic [3:0]       rep, rep_n;      // repeats still to send after this frame
  logic [GW-1:0]    gap, gap_n;      // idle cycles left in GAP
  logic             last;            // dout of the previous cycle
  logic             done_n;
  logic             frame_end;
`ifdef FSM_SEQ_GEN_PARITY_EN
  logic             par, par_n;      // even parity of the latched pattern
`endif

  // State and datapath registers; reset clears everything to idle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
      pat   <= '0;
      rep   <= '0;
      gap   <= '0;
      last  <= IDLE_BIT;
      done  <= 1'b0;
`ifdef FSM_SEQ_GEN_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sh    <= sh_n;
      pat   <= pat_n;
      rep   <= rep_n;
      gap   <= gap_n;
      last  <= dout;
      done  <= done_n;
`ifdef FSM_SEQ_GEN_PARITY_EN
      par   <= par_n;
`endif
    end
  end

  // Next-state and output decode. dout is combinational so the first bit is
  // visible in the cycle right after start; during a stall it repeats the
  // previous cycle's value via 'last'.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sh_n       = sh;
    pat_n      = pat;
    rep_n      = rep;
    gap_n      = gap;
    done_n     = 1'b0;
    frame_end  = 1'b0;
    dout       = IDLE_BIT;
    dout_valid = 1'b0;
`ifdef FSM_SEQ_GEN_PARITY_EN
    par_n      = par;
`endif
    case (state)
      IDLE: begin
        // The done cycle is itself IDLE; a start coinciding with it is dropped.
        if (start && !done) begin
          state_n = SHIFT;
          pat_n   = pattern;
          sh_n    = pattern;
          rep_n   = rpt;
          cnt_n   = '0;
`ifdef FSM_SEQ_GEN_PARITY_EN
          par_n   = ^pattern;
`endif
        end
      end
      SHIFT: begin
        dout = last;
        if (!hold) begin
          dout       = sh[WIDTH-1];
          dout_valid = 1'b1;
          sh_n       = {sh[WIDTH-2:0], 1'b0};
          if (cnt == LAST_BIT) begin
            cnt_n = '0;
`ifdef FSM_SEQ_GEN_PARITY_EN
            state_n = PAR;
`else
            frame_end = 1'b1;
`endif
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
`ifdef FSM_SEQ_GEN_PARITY_EN
      PAR: begin
        dout = last;
        if (!hold) begin
          dout       = par;
          dout_valid = 1'b1;
          frame_end  = 1'b1;
        end
      end
`endif
      GAP: begin
        // hold has no effect here; the gap always runs its full length.
        if (gap == '0) begin
          state_n = SHIFT;
          rep_n   = rep - 4'd1;
          sh_n    = pat;
          cnt_n   = '0;
        end else begin
          gap_n = gap - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Shared end-of-frame decision: gap, immediate restart, or finish.
    if (frame_end) begin
      if (rep != 4'd0) begin
        if (GAP_CYCLES > 0) begin
          state_n = GAP;
          gap_n   = GAP_LOAD;
        end else begin
          state_n = SHIFT;
          rep_n   = rep - 4'd1;
          sh_n    = pat;
          cnt_n   = '0;
        end
      end else begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Self-checking bench for fsm_seq_gen: directed scenarios plus randomized
// frames compared cycle by cycle against an event-list reference model.
module tb_fsm_seq_gen;
  localparam int   W   = 21;
  localparam int   GAP = 2;
  localparam logic IB  = 1'b0;
`ifdef FSM_SEQ_GEN_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam logic [W-1:0] P_BASIC = 21'b001100101100010011010;

  logic         clk = 1'b0;
  logic         rst, start, hold;
  logic [W-1:0] pattern;
  logic [3:0]   rpt;
  logic         dout, dout_valid, busy, done;

  fsm_seq_gen #(.WIDTH(W), .GAP_CYCLES(GAP), .IDLE_BIT(IB)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .rpt(rpt),
    .hold(hold), .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit hold_sched [0:511];
  bit ev [0:511];
  bit ed [0:511];
  bit eb [0:511];
  bit edn[0:511];
  int exp_len;

  // Reference: the transmission is a flat list of slots (data bits, optional
  // parity, gap slots). Data slots wait on hold, gap slots never do. After the
  // list drains comes one done cycle and one quiet cycle.
  function automatic void build_model(input logic [W-1:0] p, input int r);
    bit q_bit[$];
    bit q_gap[$];
    int c;
    bit lst;
    for (int t = 0; t <= r; t++) begin
      for (int i = W - 1; i >= 0; i--) begin q_bit.push_back(p[i]); q_gap.push_back(1'b0); end
      if (PB == 1) begin q_bit.push_back(^p); q_gap.push_back(1'b0); end
      if (t < r)
        for (int g = 0; g < GAP; g++) begin q_bit.push_back(IB); q_gap.push_back(1'b1); end
    end
    for (int k = 0; k < 512; k++) begin ev[k] = 0; ed[k] = IB; eb[k] = 0; edn[k] = 0; end
    c = 1;
    lst = IB;
    while (q_bit.size() > 0) begin
      eb[c] = 1'b1;
      if (q_gap[0]) begin
        ed[c] = IB;
        void'(q_bit.pop_front()); void'(q_gap.pop_front());
      end else if (hold_sched[c]) begin
        ed[c] = lst;
      end else begin
        ev[c] = 1'b1;
        ed[c] = q_bit[0];
        void'(q_bit.pop_front()); void'(q_gap.pop_front());
      end
      lst = ed[c];
      c++;
    end
    edn[c] = 1'b1;
    exp_len = c + 2;
  endfunction

  task automatic reset_dut();
    rst = 1'b1; start = 1'b0; hold = 1'b0; pattern = '0; rpt = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic clear_hold();
    for (int k = 0; k < 512; k++) hold_sched[k] = 1'b0;
  endtask

  // One-cycle start pulse; returns just after the accepting edge.
  task automatic launch(input logic [W-1:0] p, input logic [3:0] r);
    start = 1'b1; pattern = p; rpt = r; hold = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; hold = 1'b1; pattern = P_BASIC; rpt = 4'd3;
    @(posedge clk); @(posedge clk); @(negedge clk);
    n_tests++;
    if ({dout, dout_valid, busy, done} !== {IB, 3'b000})
      $display("FAIL reset_outputs: got %b want %b", {dout, dout_valid, busy, done}, {IB, 3'b000});
    if ({dout, dout_valid, busy, done} !== {IB, 3'b000}) n_fail++;
    #1 rst = 1'b0; start = 1'b0; hold = 1'b0;
    @(posedge clk); @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_release_idle: busy=%b want 0", busy); n_fail++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int done_at = 0;
    reset_dut(); clear_hold();
    build_model(P_BASIC, 0);
    launch(P_BASIC, 4'd0);
    for (int c = 1; c < exp_len; c++) begin
      pattern = W'($urandom); rpt = 4'($urandom);
      @(negedge clk);
      n_tests++;
      if ({dout_valid, dout, busy, done} !== {ev[c], ed[c], eb[c], edn[c]}) begin
        $display("FAIL basic cyc %0d: v/d/b/done got %b want %b", c,
                 {dout_valid, dout, busy, done}, {ev[c], ed[c], eb[c], edn[c]});
        n_fail++;
      end
      if (done === 1'b1) done_at = c;
      @(posedge clk); #1;
    end
    n_tests++;
    if (done_at != 22 + PB) begin
      $display("FAIL basic_done_time: got %0d want %0d", done_at, 22 + PB); n_fail++;
    end
  endtask

  task automatic test_stall();
    int done_at = 0;
    reset_dut(); clear_hold();
    hold_sched[6] = 1'b1; hold_sched[7] = 1'b1; hold_sched[8] = 1'b1;
    build_model(P_BASIC, 0);
    launch(P_BASIC, 4'd0);
    for (int c = 1; c < exp_len; c++) begin
      hold = hold_sched[c];
      @(negedge clk);
      n_tests++;
      if ({dout_valid, dout, busy, done} !== {ev[c], ed[c], eb[c], edn[c]}) begin
        $display("FAIL stall cyc %0d: v/d/b/done got %b want %b", c,
                 {dout_valid, dout, busy, done}, {ev[c], ed[c], eb[c], edn[c]});
        n_fail++;
      end
      if (done === 1'b1) done_at = c;
      @(posedge clk); #1;
    end
    hold = 1'b0;
    n_tests++;
    if (done_at != 25 + PB) begin
      $display("FAIL stall_done_time: got %0d want %0d", done_at, 25 + PB); n_fail++;
    end
  endtask

  task automatic test_repeat();
    int done_at = 0;
    int n_done = 0;
    reset_dut(); clear_hold();
    build_model(21'h1FFFFF, 2);
    launch(21'h1FFFFF, 4'd2);
    for (int c = 1; c < exp_len; c++) begin
      @(negedge clk);
      n_tests++;
      if ({dout_valid, dout, busy, done} !== {ev[c], ed[c], eb[c], edn[c]}) begin
        $display("FAIL repeat cyc %0d: v/d/b/done got %b want %b", c,
                 {dout_valid, dout, busy, done}, {ev[c], ed[c], eb[c], edn[c]});
        n_fail++;
      end
      if (done === 1'b1) begin done_at = c; n_done++; end
      @(posedge clk); #1;
    end
    n_tests++;
    if (done_at != 68 + 3 * PB || n_done != 1) begin
      $display("FAIL repeat_done: at %0d count %0d want at %0d count 1", done_at, n_done, 68 + 3 * PB);
      n_fail++;
    end
  endtask

  task automatic test_ignored_start();
    int n_done = 0;
    reset_dut(); clear_hold();
    build_model(P_BASIC, 0);
    launch(P_BASIC, 4'd0);
    for (int c = 1; c < exp_len; c++) begin
      start = (c == 10);
      if (c == 10) begin pattern = '0; rpt = 4'd5; end
      @(negedge clk);
      n_tests++;
      if ({dout_valid, dout, busy, done} !== {ev[c], ed[c], eb[c], edn[c]}) begin
        $display("FAIL ignored_start cyc %0d: v/d/b/done got %b want %b", c,
                 {dout_valid, dout, busy, done}, {ev[c], ed[c], eb[c], edn[c]});
        n_fail++;
      end
      if (done === 1'b1) n_done++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_tests++;
    if (n_done != 1) begin
      $display("FAIL ignored_start_done_count: got %0d want 1", n_done); n_fail++;
    end
  endtask

  task automatic test_midframe_reset();
    int n_done = 0;
    reset_dut(); clear_hold();
    build_model(P_BASIC, 0);
    launch(P_BASIC, 4'd0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      n_tests++;
      if ({dout_valid, dout, busy} !== {ev[c], ed[c], eb[c]}) begin
        $display("FAIL midreset_pre cyc %0d: got %b want %b", c,
                 {dout_valid, dout, busy}, {ev[c], ed[c], eb[c]});
        n_fail++;
      end
      if (c == 7) rst = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({dout, busy, dout_valid, done} !== {IB, 3'b000}) begin
      $display("FAIL midreset_after: d/b/v/done got %b want %b", {dout, busy, dout_valid, done}, {IB, 3'b000});
      n_fail++;
    end
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    n_tests++;
    if (n_done != 0) begin
      $display("FAIL midreset_no_done: activity cycles %0d want 0", n_done); n_fail++;
    end
    #1;
    launch(P_BASIC, 4'd0);
    for (int c = 1; c < exp_len; c++) begin
      @(negedge clk);
      n_tests++;
      if ({dout_valid, dout, busy, done} !== {ev[c], ed[c], eb[c], edn[c]}) begin
        $display("FAIL midreset_fresh cyc %0d: got %b want %b", c,
                 {dout_valid, dout, busy, done}, {ev[c], ed[c], eb[c], edn[c]});
        n_fail++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_done_start();
    bit seen = 1'b0;
    reset_dut(); clear_hold();
    launch(P_BASIC, 4'd0);
    for (int c = 1; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; start = 1'b1; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_tests++;
    if (!seen) begin
      $display("FAIL done_start_timeout: done not seen within 100 cycles"); n_fail++;
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      $display("FAIL done_start_ignored: busy=%b want 0", busy); n_fail++;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy, dout_valid, dout} !== {2'b11, P_BASIC[W-1]}) begin
      $display("FAIL done_start_next_accept: b/v/d got %b want %b", {busy, dout_valid, dout}, {2'b11, P_BASIC[W-1]});
      n_fail++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [W-1:0] p;
    logic [3:0]   r;
    reset_dut();
    for (int it = 0; it < 25; it++) begin
      p = W'($urandom);
      r = 4'($urandom_range(0, 3));
      clear_hold();
      for (int k = 1; k < 512; k++) hold_sched[k] = ($urandom_range(0, 3) == 0);
      build_model(p, int'(r));
      launch(p, r);
      for (int c = 1; c < exp_len; c++) begin
        hold    = hold_sched[c];
        pattern = W'($urandom);
        rpt     = 4'($urandom);
        start   = (c < exp_len - 1) && ($urandom_range(0, 5) == 0);
        @(negedge clk);
        n_tests++;
        if ({dout_valid, dout, busy, done} !== {ev[c], ed[c], eb[c], edn[c]}) begin
          $display("FAIL random it %0d cyc %0d: v/d/b/done got %b want %b", it, c,
                   {dout_valid, dout, busy, done}, {ev[c], ed[c], eb[c], edn[c]});
          n_fail++;
        end
        @(posedge clk); #1;
      end
      start = 1'b0; hold = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; pattern = '0; rpt = '0;
    test_reset();
    test_basic();
    test_stall();
    test_repeat();
    test_ignored_start();
    test_midframe_reset();
    test_done_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_seq_gen.md
FSM_SEQ_GEN -- requirements
Module: fsm_seq_gen

Interface
REQ-001 Parameter WIDTH, default 21, pattern length in bits (legal range 2..32).
REQ-002 Parameter GAP_CYCLES, default 2, idle cycles inserted between repeated transmissions (0 = back-to-back).
REQ-003 Parameter IDLE_BIT, default 1'b0, value driven on dout when no bit is being sent.
REQ-004 clk  input  1  single clock; all logic is rising-edge triggered.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  one-cycle request to begin a transmission; sampled only in IDLE.
REQ-007 pattern  input  WIDTH  bit sequence to send; latched on an accepted start.
REQ-008 rpt  input  4  extra repeat count; latched with pattern; rpt=N gives N+1 transmissions.
REQ-009 hold  input  1  stall from the consumer; freezes the shift sequence while high.
REQ-010 dout  output  1  serial bit stream, MSB (pattern[WIDTH-1]) first, for a sequence detector on the same clk.
REQ-011 dout_valid  output  1  high on every cycle where dout carries a new bit.
REQ-012 busy  output  1  high in every state other than IDLE.
REQ-013 done  output  1  one-cycle pulse after the final bit of the final repeat.

Function
REQ-014 States are IDLE, SHIFT, PAR (exists only with the macro), and GAP; the encoding is internal.
REQ-015 In IDLE with start=1, the block latches pattern and rpt and enters SHIFT on the next edge; the first bit appears on dout with dout_valid=1 one cycle after start.
REQ-016 In SHIFT with hold=0, the block emits one bit per cycle in order pattern[WIDTH-1] down to pattern[0]; the bit counter counts 0..WIDTH-1.
REQ-017 In SHIFT with hold=1, dout keeps its last value, dout_valid=0, and the bit, repeat and gap counters are frozen; emission resumes with the next unsent bit on the first cycle with hold=0.
REQ-018 hold is ignored in IDLE and in GAP; GAP counts down regardless of hold.
REQ-019 After bit pattern[0] is sent, the next state is chosen as follows:
- PAR, if the macro is enabled.
- GAP, if repeats remain and GAP_CYCLES>0.
- SHIFT with the bit counter reset, if repeats remain and GAP_CYCLES=0.
- IDLE, otherwise.
REQ-020 In GAP, dout=IDLE_BIT and dout_valid=0 for exactly GAP_CYCLES cycles, then SHIFT restarts with the latched pattern; the remaining-repeat counter decrements at each restart.
REQ-021 done pulses high for one cycle, on the cycle the FSM returns to IDLE; busy is low on that same cycle.
REQ-022 start asserted while busy=1 is ignored and is not queued; changes to pattern or rpt during a transmission have no effect.
REQ-023 start asserted on the same cycle that done pulses is ignored; a new start is accepted from the following cycle.
REQ-024 In IDLE, dout=IDLE_BIT and dout_valid=0.

Reset
REQ-025 rst=1 at a rising edge forces IDLE from any state and sets dout=IDLE_BIT, dout_valid=0, busy=0, done=0, and all counters to 0.
REQ-026 A reset during SHIFT, PAR or GAP aborts the transmission with no done pulse; the stream truncates cleanly at the reset edge.
REQ-027 rst has priority over start and hold on the same edge.

Configuration
REQ-028 Macro FSM_SEQ_GEN_PARITY_EN: when defined, PAR follows every transmission and sends one even-parity bit (the XOR of all WIDTH pattern bits) with dout_valid=1; hold stalls PAR the same way it stalls SHIFT.
REQ-029 When FSM_SEQ_GEN_PARITY_EN is undefined, the PAR state and the parity logic are absent, and each frame is exactly WIDTH bits.

Verification
REQ-030 Bench uses WIDTH=21, GAP_CYCLES=2 and the macro undefined unless stated otherwise.
REQ-031 Basic send: rst then release, start=1 for one cycle with pattern=21'b001100101100010011010, rpt=0.
- Required: dout shows 0,0,1,1,0,0,1,0,1,1,0,0,0,1,0,0,1,1,0,1,0 on 21 consecutive valid cycles starting 1 cycle after start.
- Required: done pulses 22 cycles after start.
REQ-032 Stall: same pattern; hold=1 for 3 cycles after the 5th bit.
- Required: dout_valid=0 for those 3 cycles and the bit order is unchanged.
- Required: done is delayed by exactly 3 cycles (25 cycles after start).
REQ-033 Repeat: rpt=2, pattern=21'h1FFFFF.
- Required: 3 frames of 21 ones, each separated by 2 cycles with dout_valid=0.
- Required: busy stays high throughout and done pulses once, at 68 cycles after start.
REQ-034 Ignored start: pulse start again at bit 10 with pattern=21'h0.
- Required: the original frame is unaffected and exactly one done pulse occurs.
REQ-035 Mid-frame reset: assert rst at bit 7.
- Required: the next edge gives dout=0, busy=0, dout_valid=0, with no done pulse.
- Required: a fresh start afterwards transmits the full frame.
REQ-036 Parity (macro defined): pattern=21'b001100101100010011010.
- Required: the 22nd valid bit is 1 (the pattern has 9 ones, so the even-parity bit is 1).
- Required: done pulses 23 cycles after start.
